// File: rtl/load_store_unit.sv
// RV32E load/store unit in front of the 16K x 32 byte-maskable data RAM.
// One request in flight: IDLE -> ACCESS -> RESP, or IDLE -> RESP for rejected accesses.
module load_store_unit #(
  parameter int ADDR_WORDS_LOG2 = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [2:0]                 req_funct3,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       resp_valid,
  output logic [31:0]                resp_rdata,
  output logic                       resp_error,
  output logic [3:0]                 mem_write_mask,
  output logic [ADDR_WORDS_LOG2-1:0] mem_addr,
  output logic [31:0]                mem_write_data,
  input  logic [31:0]                mem_read_data
);

  localparam int BA_W = ADDR_WORDS_LOG2 + 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  function automatic logic req_illegal(input logic wr, input logic [2:0] f3,
                                       input logic [31:0] a);
    logic out_of_range, bad_f3, misalign;
    out_of_range = |a[31:BA_W];
    bad_f3       = wr ? (f3 > 3'b010) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
    misalign     = ((f3[1:0] == 2'b01) && a[0]) ||
                   ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
    return out_of_range || bad_f3 || misalign;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [31:0]        res;
    byte_s = word[{lane, 3'b000} +: 8];
    half_s = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  res = 32'(byte_s);
      3'b001:  res = 32'(half_s);
      3'b100:  res = {24'd0, byte_s};
      3'b101:  res = {16'd0, half_s};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  logic [1:0]                 state_q, state_d;
  logic                       write_q, write_d;
  logic [2:0]                 funct3_q, funct3_d;
  logic [1:0]                 lane_q, lane_d;
  logic                       err_q, err_d;
  logic [ADDR_WORDS_LOG2-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]                mem_wdata_q, mem_wdata_d;
  logic                       resp_valid_q, resp_valid_d;
  logic [31:0]                resp_rdata_q, resp_rdata_d;
  logic                       resp_error_q, resp_error_d;
  logic                       req_err;

  assign req_err = req_illegal(req_write, req_funct3, req_addr);

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    err_d        = err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          lane_d   = req_addr[1:0];
          err_d    = req_err;
          state_d  = req_err ? RESP : ACCESS;
          // Rejected requests leave the memory-side registers untouched.
          if (!req_err) begin
            mem_addr_d = req_addr[BA_W-1:2];
            if (req_write) mem_wdata_d = store_data(req_funct3, req_wdata);
          end
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_error_d = err_q;
        // RAM read data for the word presented in ACCESS is valid now.
        if (!err_q && !write_q) resp_rdata_d = load_extract(funct3_q, lane_q, mem_read_data);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      lane_q       <= 2'd0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Reset gates the write strobe combinationally so an in-flight store never lands.
  assign mem_write_mask = (state_q == ACCESS && write_q && !rst) ?
                          store_mask(funct3_q, lane_q) : 4'b0000;
  assign req_ready      = (state_q == IDLE);
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_error     = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: RAM stand-in, transaction-level reference model
// checked every cycle, directed literal cases, then randomized traffic with resets.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata, mem_write_data;
  logic [3:0]  mem_write_mask;
  logic [13:0] mem_addr;
  logic [31:0] ram_rd;

  int tests = 0;
  int fails = 0;

  load_store_unit #(.ADDR_WORDS_LOG2(14)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_write_mask(mem_write_mask), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(ram_rd)
  );

  always #5 clk = ~clk;

  // memory_group stand-in: synchronous byte-masked write, one-cycle read latency
  bit [31:0] ram [0:16383];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (mem_write_mask[k]) ram[mem_addr][8*k +: 8] <= mem_write_data[8*k +: 8];
    ram_rd <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit [31:0]   ref_mem [0:16383];
  int          cyc = 0, idle_from = 0, resp_edge = -1, access_edge = -1;
  bit          model_on = 0;
  logic [31:0] exp_rdata;
  bit          exp_err;
  logic [13:0] exp_maddr = '0;
  bit          acc_store;
  int          acc_off, acc_n;
  logic [13:0] acc_idx;
  logic [31:0] acc_wd, acc_wdata;
  logic [3:0]  acc_mask;

  function automatic bit model_err(input bit w, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int n;
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = 1 << f3[1:0];
    return (a >= 32'h0001_0000) || !legal || ((a % n) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    logic [31:0] v;
    int off;
    off = a % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (word >> (8 * (off & 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic model_step();
    cyc++;
    if (access_edge == cyc - 1 && acc_store && !rst)
      for (int j = 0; j < acc_n; j++) ref_mem[acc_idx][8*(acc_off+j) +: 8] = acc_wd[8*j +: 8];
    if (rst) begin
      model_on = 1; idle_from = cyc; resp_edge = -1; access_edge = -1; exp_maddr = '0;
    end else if (model_on && (cyc - 1 >= idle_from) && req_valid) begin
      if (model_err(req_write, req_funct3, req_addr)) begin
        exp_err = 1; exp_rdata = 0; resp_edge = cyc + 1; idle_from = cyc + 1;
      end else begin
        exp_err = 0; resp_edge = cyc + 2; idle_from = cyc + 2; access_edge = cyc;
        acc_store = req_write; acc_idx = req_addr[15:2]; exp_maddr = req_addr[15:2];
        acc_off = req_addr % 4; acc_n = 1 << req_funct3[1:0]; acc_wd = req_wdata;
        acc_mask = '0;
        for (int j = 0; j < acc_n; j++) acc_mask[acc_off + j] = 1'b1;
        for (int k = 0; k < 4; k++) acc_wdata[8*k +: 8] = req_wdata[8*(k % acc_n) +: 8];
        exp_rdata = req_write ? 32'd0 : model_load(req_funct3, req_addr, ref_mem[acc_idx]);
      end
    end
  endtask

  task automatic compare();
    bit rv, in_acc;
    rv = (cyc == resp_edge);
    in_acc = (cyc == access_edge);
    chk("req_ready", 32'(req_ready), 32'(cyc >= idle_from));
    chk("resp_valid", 32'(resp_valid), 32'(rv));
    chk("resp_error", 32'(resp_error), rv ? 32'(exp_err) : 32'd0);
    chk("resp_rdata", resp_rdata, rv ? exp_rdata : 32'd0);
    chk("mem_write_mask", 32'(mem_write_mask), (in_acc && acc_store && !rst) ? 32'(acc_mask) : 32'd0);
    chk("mem_addr", 32'(mem_addr), 32'(exp_maddr));
    if (in_acc && acc_store) chk("mem_write_data", mem_write_data, acc_wdata);
  endtask

  task automatic monitor();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (model_on) compare();
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output bit er,
                        output logic [3:0] mk, output logic [31:0] mwd,
                        output logic [13:0] ma, output int lat);
    int n;
    rd = '0; er = 0; mk = '0; mwd = '0; ma = '0; lat = -1;
    @(negedge clk);
    req_valid = 1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    mk = mem_write_mask; mwd = mem_write_data; ma = mem_addr;
    n = 0;
    while (!resp_valid && n < 8) begin @(negedge clk); n++; end
    if (!resp_valid) begin
      chk("resp_timeout", 32'(resp_valid), 32'd1);
      return;
    end
    rd = resp_rdata; er = resp_error; lat = n;
  endtask

  task automatic load_chk(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    logic [31:0] rd, mwd;
    bit er;
    logic [3:0] mk;
    logic [13:0] ma;
    int lat;
    do_req(0, f3, a, 32'd0, rd, er, mk, mwd, ma, lat);
    chk(name, rd, exp);
    chk({name, "_err"}, 32'(er), 32'd0);
  endtask

  task automatic err_chk(input string name, input bit w, input logic [2:0] f3,
                         input logic [31:0] a);
    logic [31:0] rd, mwd;
    bit er;
    logic [3:0] mk;
    logic [13:0] ma;
    int lat;
    do_req(w, f3, a, 32'hFFFF_FFFF, rd, er, mk, mwd, ma, lat);
    chk({name, "_err"}, 32'(er), 32'd1);
    chk({name, "_rdata"}, rd, 32'd0);
    chk({name, "_lat"}, 32'(lat), 32'd1);
    chk({name, "_mask"}, 32'(mk), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, mwd;
    bit er, took, alt;
    logic [3:0] mk;
    logic [13:0] ma;
    int lat, cnt;

    rst = 1; req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_maddr", 32'(mem_addr), 32'd0);
    rst = 0;

    do_req(1, 3'b010, 32'h10, 32'h77FF_8855, rd, er, mk, mwd, ma, lat);
    chk("sw_mask", 32'(mk), 32'hF);
    chk("sw_wdata", mwd, 32'h77FF_8855);
    chk("sw_maddr", 32'(ma), 32'd4);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_err", 32'(er), 32'd0);
    load_chk("lw_10", 3'b010, 32'h10, 32'h77FF_8855);
    load_chk("lb_11", 3'b000, 32'h11, 32'hFFFF_FF88);
    load_chk("lbu_11", 3'b100, 32'h11, 32'h0000_0088);
    load_chk("lh_12", 3'b001, 32'h12, 32'h0000_77FF);
    load_chk("lhu_10", 3'b101, 32'h10, 32'h0000_8855);

    do_req(1, 3'b000, 32'h13, 32'h0000_00AB, rd, er, mk, mwd, ma, lat);
    chk("sb_mask", 32'(mk), 32'h8);
    chk("sb_wdata", mwd, 32'hABAB_ABAB);
    load_chk("lw_after_sb", 3'b010, 32'h10, 32'hABFF_8855);

    err_chk("lw_misal", 0, 3'b010, 32'h12);
    err_chk("sh_misal", 1, 3'b001, 32'h11);
    err_chk("lw_range", 0, 3'b010, 32'h0001_0000);
    err_chk("ld_f3_011", 0, 3'b011, 32'h10);
    load_chk("lw_unchanged", 3'b010, 32'h10, 32'hABFF_8855);

    do_req(1, 3'b010, 32'h20, 32'h1234_5678, rd, er, mk, mwd, ma, lat);
    // store whose ACCESS cycle is hit by reset
    @(negedge clk);
    req_valid = 1; req_write = 1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) cnt++;
      @(negedge clk);
    end
    chk("post_rst_no_resp", 32'(cnt), 32'd0);
    load_chk("lw_20_kept", 3'b010, 32'h20, 32'h1234_5678);

    // continuous req_valid: one accept every third cycle
    req_valid = 1; req_write = 0; req_funct3 = 3'b010; req_addr = 32'h10;
    cnt = 0; alt = 0;
    for (int i = 0; i < 12; i++) begin
      took = req_ready;
      if (took) cnt++;
      @(negedge clk);
      if (took) begin
        alt = !alt;
        req_funct3 = alt ? 3'b000 : 3'b010;
        req_addr = alt ? 32'h13 : 32'h10;
      end
    end
    req_valid = 0;
    chk("throughput_accepts", 32'(cnt), 32'd4);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_write  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 127));
      req_wdata  = $urandom;
      @(negedge clk);
    end
    rst = 0; req_valid = 0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
